// File: rtl/tpu_seq_ctrl_if.sv
// Command, input-stream and readout handshake bundle for tpu_seq_ctrl.
// The controller takes the slave view; whoever issues commands takes the master view.
interface tpu_seq_ctrl_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data,
    input  cmd_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data,
    output cmd_ready, out_valid, out_data
  );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// Sequencer for an N x N systolic array: loads A/B buffers, streams skewed
// row/column feeds during COMPUTE, then drains the result chain during READ.
module tpu_seq_ctrl #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  tpu_seq_ctrl_if.slave   bus,
  output logic            busy,
  output logic            err,
  output logic            arr_clr,
  output logic [N*DW-1:0] arr_a,
  output logic [N*DW-1:0] arr_b,
  output logic            arr_chain_en,
  input  logic [DW-1:0]   arr_chain_in
);

  localparam int NN   = N * N;
  localparam int AW   = $clog2(NN);
  localparam int KMAX = (NN > 3 * N) ? NN : 3 * N;
  localparam int CW   = $clog2(KMAX + 1);
  localparam logic [CW-1:0] K_LOAD_LAST = CW'(NN - 1);
  localparam logic [CW-1:0] K_COMP_LAST = CW'(3 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_READ
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD_A  = 2'b00,
    OP_LOAD_B  = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] b_q [NN];
  logic          loaded_a_q, loaded_a_d;
  logic          loaded_b_q, loaded_b_d;
  logic          err_q, err_d;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          idle, cmd_fire, a_we, b_we;
  op_e           op;

  assign idle     = (state_q == S_IDLE);
  assign cmd_fire = bus.cmd_valid && idle;
  assign op       = op_e'(bus.cmd_op);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    loaded_a_d = loaded_a_q;
    loaded_b_d = loaded_b_q;
    err_d      = err_q;
    a_we       = 1'b0;
    b_we       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          k_d = '0;
          case (op)
            OP_LOAD_A: state_d = S_LOAD_A;
            OP_LOAD_B: state_d = S_LOAD_B;
            OP_COMPUTE: begin
              state_d = S_COMPUTE;
              // Runs anyway on whatever the buffers hold; the flag records the misuse.
              if (!(loaded_a_q && loaded_b_q)) err_d = 1'b1;
            end
            default:   state_d = S_READ;
          endcase
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (bus.in_valid) begin
          a_we = (state_q == S_LOAD_A);
          b_we = (state_q == S_LOAD_B);
          if (k_q == K_LOAD_LAST) begin
            state_d = S_IDLE;
            k_d     = '0;
            if (state_q == S_LOAD_A) loaded_a_d = 1'b1;
            else                     loaded_b_d = 1'b1;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end

      S_COMPUTE: begin
        if (k_q == K_COMP_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + CW'(1);
        end
      end

      S_READ: begin
        if (k_q == K_LOAD_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Feed step t = k-1; lane l carries element (l, t-l) of A and (t-l, l) of B,
  // so iterating over the in-lane offset d and matching l+d+1 == k covers the
  // whole wavefront and leaves c=0 and the drain steps at zero.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (state_q == S_COMPUTE) begin
      for (int l = 0; l < N; l++) begin
        for (int d = 0; d < N; d++) begin
          if (CW'(l + d + 1) == k_q) begin
            arr_a[l*DW +: DW] = a_q[AW'(l*N + d)];
            arr_b[l*DW +: DW] = b_q[AW'(d*N + l)];
          end
        end
      end
    end
  end

  assign arr_clr       = (state_q == S_COMPUTE) && (k_q == '0);
  assign arr_chain_en  = (state_q == S_READ);
  assign bus.cmd_ready = idle;
  assign busy          = !idle;
  assign err           = err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // NOTE: the matrix buffers are cleared by reset too, because a COMPUTE issued before any load must see zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      loaded_a_q  <= 1'b0;
      loaded_b_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NN; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      loaded_a_q  <= loaded_a_d;
      loaded_b_q  <= loaded_b_d;
      err_q       <= err_d;
      out_valid_q <= arr_chain_en;
      if (arr_chain_en) out_data_q <= arr_chain_in;
      if (a_we) a_q[k_q[AW-1:0]] <= bus.in_data;
      if (b_we) b_q[k_q[AW-1:0]] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Self-checking bench for tpu_seq_ctrl (N=2, DW=8): a directed cycle table,
// hand-written stall/reset sequences, and randomized commands against a matrix-level model.
module tb_tpu_seq_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int OP_LOAD_A  = 0;
  localparam int OP_LOAD_B  = 1;
  localparam int OP_COMPUTE = 2;
  localparam int OP_READ    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy, err, arr_clr, arr_chain_en;
  logic [N*DW-1:0] arr_a, arr_b;
  logic [DW-1:0]   arr_chain_in;

  always #5 clk = ~clk;

  tpu_seq_ctrl_if #(.DW(DW)) bus ();

  tpu_seq_ctrl #(.N(N), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .err          (err),
    .arr_clr      (arr_clr),
    .arr_a        (arr_a),
    .arr_b        (arr_b),
    .arr_chain_en (arr_chain_en),
    .arr_chain_in (arr_chain_in)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: matrices, loaded flags, sticky error, last read word.
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  bit            la, lb, merr;
  logic [DW-1:0] m_od;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit rdy, input bit clr,
                            input logic [N*DW-1:0] ea, input logic [N*DW-1:0] eb,
                            input bit ch, input bit ov);
    check({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'(rdy));
    check({tag, ".busy"},      64'(busy),          64'(!rdy));
    check({tag, ".arr_clr"},   64'(arr_clr),       64'(clr));
    check({tag, ".arr_a"},     64'(arr_a),         64'(ea));
    check({tag, ".arr_b"},     64'(arr_b),         64'(eb));
    check({tag, ".chain_en"},  64'(arr_chain_en),  64'(ch));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, ".out_data"},  64'(bus.out_data),  64'(m_od));
    check({tag, ".err"},       64'(err),           64'(merr));
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    la = 1'b0; lb = 1'b0; merr = 1'b0; m_od = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    arr_chain_in  = '0;
  endtask

  // One idle cycle in which a command is presented (accepted at the next edge).
  task automatic cmd(input int op);
    step();
    check_outs("cmd_idle", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = DW'($urandom);
    arr_chain_in  = DW'($urandom);
  endtask

  // Feed NN words with random gaps; optionally hold the next command pending.
  task automatic load(input bit is_b, input logic [DW-1:0] w [NN], input bit hold, input int hold_op);
    for (int i = 0; i < NN; i++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g <= gaps; g++) begin
        step();
        check_outs(is_b ? "load_b" : "load_a", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        bus.cmd_valid = hold;
        bus.cmd_op    = 2'(hold_op);
        bus.in_valid  = (g == gaps);
        bus.in_data   = (g == gaps) ? w[i] : DW'($urandom);
      end
    end
    for (int i = 0; i < NN; i++) begin
      if (is_b) mb[i / N][i % N] = w[i];
      else      ma[i / N][i % N] = w[i];
    end
    if (is_b) lb = 1'b1;
    else      la = 1'b1;
  endtask

  // abort_step >= 0 pulses reset asynchronously during that feed step.
  task automatic compute(input int abort_step);
    logic [DW-1:0]   sa [N][3*N-2];
    logic [DW-1:0]   sb [N][3*N-2];
    logic [N*DW-1:0] ea, eb;
    // Row i of A enters lane i delayed by i steps; column j of B likewise.
    for (int l = 0; l < N; l++)
      for (int s = 0; s < 3*N-2; s++) begin
        sa[l][s] = '0;
        sb[l][s] = '0;
      end
    for (int l = 0; l < N; l++)
      for (int r = 0; r < N; r++) begin
        sa[l][l + r] = ma[l][r];
        sb[l][l + r] = mb[r][l];
      end
    if (!(la && lb)) merr = 1'b1;
    step();
    check_outs("cmp_c0", 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = DW'($urandom);
    for (int s = 0; s < 3*N-2; s++) begin
      for (int l = 0; l < N; l++) begin
        ea[l*DW +: DW] = sa[l][s];
        eb[l*DW +: DW] = sb[l][s];
      end
      step();
      check_outs($sformatf("cmp_t%0d", s), 1'b0, 1'b0, ea, eb, 1'b0, 1'b0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = DW'($urandom);
      if (s == abort_step) begin
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_outs("rst_async", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        quiet_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic read(input logic [DW-1:0] w [NN]);
    for (int i = 0; i < NN; i++) begin
      step();
      if (i > 0) m_od = w[i-1];
      check_outs($sformatf("read%0d", i), 1'b0, 1'b0, '0, '0, 1'b1, i > 0);
      bus.cmd_valid = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      arr_chain_in  = w[i];
    end
    step();
    m_od = w[NN-1];
    check_outs("read_tail", 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    arr_chain_in = DW'($urandom);
  endtask

  task automatic random_ops(input int count);
    logic [DW-1:0] w [NN];
    for (int n = 0; n < count; n++) begin
      int op = $urandom_range(0, 3);
      for (int i = 0; i < NN; i++) w[i] = DW'($urandom);
      cmd(op);
      case (op)
        OP_LOAD_A:  load(1'b0, w, 1'b0, 0);
        OP_LOAD_B:  load(1'b1, w, 1'b0, 0);
        OP_COMPUTE: compute(-1);
        default:    read(w);
      endcase
    end
  endtask

  // Directed cycle table: inputs driven after checking the expected outputs of that cycle.
  typedef struct {
    int cv, op, iv, id, ci;
    int rdy, clr, ea, eb, ch, ov, od;
  } vec_t;

  function automatic vec_t mk(int cv, int op, int iv, int id, int ci,
                              int rdy, int clr, int ea, int eb, int ch, int ov, int od);
    vec_t v;
    v.cv = cv; v.op = op; v.iv = iv; v.id = id; v.ci = ci;
    v.rdy = rdy; v.clr = clr; v.ea = ea; v.eb = eb; v.ch = ch; v.ov = ov; v.od = od;
    return v;
  endfunction

  initial begin
    vec_t          tbl [$];
    logic [DW-1:0] w [NN];
    logic [DW-1:0] rw [NN];

    //              cv op iv id    ci   rdy clr ea      eb      ch ov od
    tbl.push_back(mk(1, 0, 0, 0,    0,   1,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h77, 0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,    0,   1,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 'h99, 0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0,    0,   1,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'hFF, 0,   0,  1, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'hEE, 0,   0,  0, 'h0001, 'h0005, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0, 'h0302, 'h0607, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0, 'h0400, 'h0800, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,   0,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 'hAA, 0,   1,  0, 0,      0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    19,  0,  0, 0,      0,      1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    22,  0,  0, 0,      0,      1, 1, 19));
    tbl.push_back(mk(0, 0, 0, 0,    43,  0,  0, 0,      0,      1, 1, 22));
    tbl.push_back(mk(0, 0, 0, 0,    50,  0,  0, 0,      0,      1, 1, 43));
    tbl.push_back(mk(0, 0, 0, 0,    0,   1,  0, 0,      0,      0, 1, 50));
    tbl.push_back(mk(0, 0, 0, 0,    0,   1,  0, 0,      0,      0, 0, 50));

    quiet_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    check_outs("in_reset", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("tbl%0d.cmd_ready", i), 64'(bus.cmd_ready), 64'(tbl[i].rdy));
      check($sformatf("tbl%0d.busy", i),      64'(busy),          64'(tbl[i].rdy == 0));
      check($sformatf("tbl%0d.arr_clr", i),   64'(arr_clr),       64'(tbl[i].clr));
      check($sformatf("tbl%0d.arr_a", i),     64'(arr_a),         64'(tbl[i].ea));
      check($sformatf("tbl%0d.arr_b", i),     64'(arr_b),         64'(tbl[i].eb));
      check($sformatf("tbl%0d.chain_en", i),  64'(arr_chain_en),  64'(tbl[i].ch));
      check($sformatf("tbl%0d.out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      check($sformatf("tbl%0d.out_data", i),  64'(bus.out_data),  64'(tbl[i].od));
      check($sformatf("tbl%0d.err", i),       64'(err),           64'd0);
      bus.cmd_valid = 1'(tbl[i].cv);
      bus.cmd_op    = 2'(tbl[i].op);
      bus.in_valid  = 1'(tbl[i].iv);
      bus.in_data   = DW'(tbl[i].id);
      arr_chain_in  = DW'(tbl[i].ci);
    end

    ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
    mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    la = 1'b1; lb = 1'b1; merr = 1'b0; m_od = 8'd50;

    // READ held pending through a whole LOAD_A: must be taken right after return to IDLE.
    for (int i = 0; i < NN; i++) begin
      w[i]  = DW'($urandom);
      rw[i] = DW'($urandom);
    end
    cmd(OP_LOAD_A);
    load(1'b0, w, 1'b1, OP_READ);
    step();
    check_outs("stall_idle", 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    read(rw);
    cmd(OP_COMPUTE);
    compute(-1);

    random_ops(40);

    // Reset pulsed at feed step t1, then COMPUTE on cleared buffers must flag err.
    cmd(OP_COMPUTE);
    compute(1);
    cmd(OP_COMPUTE);
    compute(-1);

    random_ops(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
